// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave-side bus bundle for the PPC-to-fabric register bank.
`default_nettype none

interface opb_register_bank_ppc2simulink_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

`default_nettype wire

// File: rtl/opb_register_bank_ppc2simulink.sv
// NUM_REGS PPC-writable registers in one OPB window, each driving a fabric word
// with an update strobe; optional shadow+commit mode applies all writes at once.
`default_nettype none

module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR = 32'h01000000,
  parameter logic [31:0] C_HIGHADDR = 32'h010000FF,
  parameter int          NUM_REGS   = 4,
  parameter int          ATOMIC     = 0,
  parameter logic [31:0] RESET_VAL  = 32'h00000000
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst_n,
  opb_register_bank_ppc2simulink_if.slave opb,
  output logic [NUM_REGS*32-1:0]     user_data_out,
  output logic [NUM_REGS-1:0]        user_update
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, WAIT = 2'd2} state_t;

  state_t      state, state_next;
  logic [31:0] data_q   [NUM_REGS];
  logic [31:0] shadow_q [NUM_REGS];
  logic        commit_pending;

  logic [31:0] addr, addr_diff, wdata, rdata;
  logic [29:0] offset;
  logic [3:0]  be_user;
  logic        hit, is_reg, is_ctrl, do_write, do_commit;
  logic        unused_ok;

  // Bus bit 0 is the MSB, so a straight vector copy yields user bit order.
  assign addr      = opb.OPB_ABus;
  assign wdata     = opb.OPB_DBus;
  assign addr_diff = addr - C_BASEADDR;
  assign offset    = addr_diff[31:2];
  assign hit       = opb.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign is_reg    = offset < 30'(NUM_REGS);
  assign is_ctrl   = offset == 30'(NUM_REGS);
  assign do_write  = (state == ACK) && !opb.OPB_RNW;
  assign do_commit = do_write && is_ctrl && (ATOMIC != 0) && be_user[0] && wdata[0];
  assign unused_ok = &{1'b0, opb.OPB_seqAddr, addr_diff[1:0]};

  always_comb begin
    for (int b = 0; b < 4; b++) be_user[b] = opb.OPB_BE[3-b];
  end

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++)
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    return res;
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hit) state_next = ACK;
      ACK:     state_next = WAIT;
      WAIT:    if (!opb.OPB_select) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state          <= IDLE;
      commit_pending <= 1'b0;
      user_update    <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i]   <= RESET_VAL;
        shadow_q[i] <= RESET_VAL;
      end
    end else begin
      state       <= state_next;
      user_update <= '0;
      if (do_write && is_reg && (|be_user)) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (offset == 30'(i)) begin
            if (ATOMIC != 0) begin
              shadow_q[i]    <= merge(shadow_q[i], wdata, be_user);
              commit_pending <= 1'b1;
            end else begin
              data_q[i]      <= merge(data_q[i], wdata, be_user);
              user_update[i] <= 1'b1;
            end
          end
        end
      end
      if (do_commit) begin
        commit_pending <= 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
          data_q[i]      <= shadow_q[i];
          user_update[i] <= shadow_q[i] != data_q[i];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (is_reg) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (offset == 30'(i)) rdata = (ATOMIC != 0) ? shadow_q[i] : data_q[i];
    end else if (is_ctrl) begin
      rdata = {16'(NUM_REGS), 14'd0, (ATOMIC != 0), commit_pending};
    end
  end

  assign opb.Sl_xferAck = (state == ACK);
  assign opb.Sl_DBus    = ((state == ACK) && opb.OPB_RNW) ? rdata : 32'd0;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
      assign user_data_out[32*i +: 32] = data_q[i];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for the OPB register bank: one direct-mode and one atomic-mode instance.
`default_nettype none

module tb_opb_register_bank_ppc2simulink;
  localparam logic [31:0] BASE = 32'h01000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [0:31] abus = '0;
  logic [0:31] dbus = '0;
  logic [0:3]  be   = '0;
  logic        rnw  = 1'b0;
  logic        sel0 = 1'b0;
  logic        sel1 = 1'b0;

  opb_register_bank_ppc2simulink_if bus0 ();
  opb_register_bank_ppc2simulink_if bus1 ();

  assign bus0.OPB_ABus = abus;  assign bus1.OPB_ABus = abus;
  assign bus0.OPB_DBus = dbus;  assign bus1.OPB_DBus = dbus;
  assign bus0.OPB_BE   = be;    assign bus1.OPB_BE   = be;
  assign bus0.OPB_RNW  = rnw;   assign bus1.OPB_RNW  = rnw;
  assign bus0.OPB_seqAddr = 1'b0;
  assign bus1.OPB_seqAddr = 1'b0;
  assign bus0.OPB_select = sel0;
  assign bus1.OPB_select = sel1;

  logic [127:0] dout0, dout1;
  logic [3:0]   upd0, upd1;

  opb_register_bank_ppc2simulink #(.ATOMIC(0)) dut0 (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .opb(bus0.slave),
    .user_data_out(dout0), .user_update(upd0));

  opb_register_bank_ppc2simulink #(.ATOMIC(1)) dut1 (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .opb(bus1.slave),
    .user_data_out(dout1), .user_update(upd1));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  int           upd_cycles [2];
  logic [3:0]   upd_last   [2];
  logic [127:0] dout_at_upd[2];

  always @(negedge clk) begin
    if (|upd0) begin upd_cycles[0]++; upd_last[0] = upd0; dout_at_upd[0] = dout0; end
    if (|upd1) begin upd_cycles[1]++; upd_last[1] = upd1; dout_at_upd[1] = dout1; end
  end

  function automatic logic ack_of(input int t);
    return (t == 0) ? bus0.Sl_xferAck : bus1.Sl_xferAck;
  endfunction

  function automatic logic [31:0] dbus_of(input int t);
    return (t == 0) ? bus0.Sl_DBus : bus1.Sl_DBus;
  endfunction

  task automatic clear_upd();
    upd_cycles[0] = 0; upd_cycles[1] = 0;
    upd_last[0] = '0;  upd_last[1] = '0;
  endtask

  // One bounded OPB transfer; read data goes to got_q for scoreboard compare.
  task automatic xfer(input int t, input bit rd, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] be_in, input int hold,
                      output int lat, output int nacks, output int dbad);
    @(posedge clk); #1;
    abus = addr; dbus = data; be = be_in; rnw = rd;
    if (t == 0) sel0 = 1'b1; else sel1 = 1'b1;
    lat = -1; nacks = 0; dbad = 0;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      if (ack_of(t)) begin
        nacks++;
        if (lat < 0) lat = c;
        if (rd) got_q.push_back(dbus_of(t));
      end else if (dbus_of(t) !== 32'd0) dbad++;
    end
    @(posedge clk); #1;
    sel0 = 1'b0; sel1 = 1'b0; rnw = 1'b0;
    @(negedge clk);
    if (ack_of(t)) nacks++;
    else if (dbus_of(t) !== 32'd0) dbad++;
  endtask

  task automatic test_reset();
    int lat, nacks, dbad;
    checks++;
    if (dout0 !== 128'd0 || upd0 !== 4'd0 || bus0.Sl_xferAck !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got dout=%h upd=%b ack=%b exp 0", dout0, upd0, bus0.Sl_xferAck);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h0);
      xfer(0, 1'b1, BASE + 32'(4*i), 32'h0, 4'hF, 3, lat, nacks, dbad);
      checks++;
      if (lat !== 1 || nacks !== 1) begin
        errors++; $display("FAIL reset_read_ack got lat=%0d acks=%0d exp lat=1 acks=1", lat, nacks);
      end
    end
    exp_q.push_back(32'h00040000);
    xfer(0, 1'b1, BASE + 32'd16, 32'h0, 4'hF, 3, lat, nacks, dbad);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL reset_readback got %h exp %h", g, e); end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL reset_missing_reads got %0d exp 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_direct_write();
    int lat, nacks, dbad;
    clear_upd();
    xfer(0, 1'b0, BASE + 32'd8, 32'hDEADBEEF, 4'hF, 3, lat, nacks, dbad);
    checks++;
    if (dout0[95:64] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL direct_out got %h exp DEADBEEF", dout0[95:64]);
    end
    checks++;
    if (upd_cycles[0] !== 1 || upd_last[0] !== 4'b0100) begin
      errors++; $display("FAIL direct_update got cycles=%0d pat=%b exp 1 0100", upd_cycles[0], upd_last[0]);
    end
    checks++;
    if (dout_at_upd[0][95:64] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL direct_update_align got %h exp DEADBEEF", dout_at_upd[0][95:64]);
    end
    exp_q.push_back(32'hDEADBEEF);
    xfer(0, 1'b1, BASE + 32'd8, 32'h0, 4'hF, 3, lat, nacks, dbad);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL direct_readback got %h exp %h", g, e); end
    end
  endtask

  task automatic test_byte_enable();
    int lat, nacks, dbad;
    xfer(0, 1'b0, BASE + 32'd4, 32'h11223344, 4'hF, 3, lat, nacks, dbad);
    clear_upd();
    xfer(0, 1'b0, BASE + 32'd4, 32'hAABBCCDD, 4'b0101, 3, lat, nacks, dbad);
    checks++;
    if (dout0[63:32] !== 32'h11BB33DD || upd_last[0] !== 4'b0010) begin
      errors++; $display("FAIL byte_enable got %h upd=%b exp 11BB33DD 0010", dout0[63:32], upd_last[0]);
    end
    clear_upd();
    xfer(0, 1'b0, BASE + 32'd8, 32'h12345678, 4'b0000, 3, lat, nacks, dbad);
    checks++;
    if (nacks !== 1 || upd_cycles[0] !== 0 || dout0[95:64] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL no_be got acks=%0d upd=%0d reg=%h exp 1 0 DEADBEEF", nacks, upd_cycles[0], dout0[95:64]);
    end
    xfer(0, 1'b0, BASE + 32'd16, 32'h1, 4'hF, 3, lat, nacks, dbad);
    exp_q.push_back(32'h00040000);
    xfer(0, 1'b1, BASE + 32'd16, 32'h0, 4'hF, 3, lat, nacks, dbad);
    exp_q.push_back(32'h11BB33DD);
    xfer(0, 1'b1, BASE + 32'd4, 32'h0, 4'hF, 3, lat, nacks, dbad);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL byte_enable_read got %h exp %h", g, e); end
    end
  endtask

  task automatic test_atomic();
    int lat, nacks, dbad;
    clear_upd();
    xfer(1, 1'b0, BASE, 32'h5, 4'hF, 3, lat, nacks, dbad);
    checks++;
    if (dout1[31:0] !== 32'h0 || upd_cycles[1] !== 0) begin
      errors++; $display("FAIL atomic_staged got %h upd=%0d exp 0 0", dout1[31:0], upd_cycles[1]);
    end
    exp_q.push_back(32'h00040003);
    xfer(1, 1'b1, BASE + 32'd16, 32'h0, 4'hF, 3, lat, nacks, dbad);
    exp_q.push_back(32'h5);
    xfer(1, 1'b1, BASE, 32'h0, 4'hF, 3, lat, nacks, dbad);
    xfer(1, 1'b0, BASE + 32'd16, 32'h1, 4'hF, 3, lat, nacks, dbad);
    checks++;
    if (dout1[31:0] !== 32'h5 || upd_cycles[1] !== 1 || upd_last[1] !== 4'b0001) begin
      errors++; $display("FAIL atomic_commit got %h cycles=%0d pat=%b exp 5 1 0001", dout1[31:0], upd_cycles[1], upd_last[1]);
    end
    exp_q.push_back(32'h00040002);
    xfer(1, 1'b1, BASE + 32'd16, 32'h0, 4'hF, 3, lat, nacks, dbad);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL atomic_read got %h exp %h", g, e); end
    end
  endtask

  task automatic test_hold_select();
    int lat, nacks, dbad;
    logic [127:0] snap_exp;
    snap_exp = {32'h0, 32'hDEADBEEF, 32'h11BB33DD, 32'h0};
    exp_q.push_back(32'hDEADBEEF);
    xfer(0, 1'b1, BASE + 32'd8, 32'h0, 4'hF, 5, lat, nacks, dbad);
    checks++;
    if (nacks !== 1 || dbad !== 0) begin
      errors++; $display("FAIL hold_select got acks=%0d dbus_bad=%0d exp 1 0", nacks, dbad);
    end
    clear_upd();
    xfer(0, 1'b0, BASE + 32'd40, 32'hFFFFFFFF, 4'hF, 3, lat, nacks, dbad);
    checks++;
    if (nacks !== 1 || dout0 !== snap_exp || upd_cycles[0] !== 0) begin
      errors++; $display("FAIL off10_write got acks=%0d dout=%h exp 1 %h", nacks, dout0, snap_exp);
    end
    exp_q.push_back(32'h0);
    xfer(0, 1'b1, BASE + 32'd40, 32'h0, 4'hF, 3, lat, nacks, dbad);
    xfer(0, 1'b1, 32'h01000100, 32'h0, 4'hF, 3, lat, nacks, dbad);
    checks++;
    if (nacks !== 0) begin errors++; $display("FAIL out_of_window got acks=%0d exp 0", nacks); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL hold_read got %h exp %h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, nacks, dbad;
    logic [31:0] vals [4];
    for (int i = 0; i < 4; i++) begin
      vals[i] = $urandom;
      xfer(0, 1'b0, BASE + 32'(4*i), vals[i], 4'hF, 3, lat, nacks, dbad);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(vals[i]);
      xfer(0, 1'b1, BASE + 32'(4*i), 32'h0, 4'hF, 3, lat, nacks, dbad);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_read got %h exp %h", g, e); end
    end
  endtask

  task automatic test_reset_in_wait();
    int lat, nacks, dbad, stray;
    @(posedge clk); #1;
    abus = BASE; dbus = 32'hCAFEF00D; be = 4'b1111; rnw = 1'b0; sel0 = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (dout0[31:0] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL pre_reset_write got %h exp CAFEF00D", dout0[31:0]);
    end
    rst_n = 1'b0; #1;
    checks++;
    if (dout0 !== 128'd0 || dout1 !== 128'd0 || upd0 !== 4'd0 || bus0.Sl_xferAck !== 1'b0 || bus0.Sl_DBus !== 32'd0) begin
      errors++; $display("FAIL async_reset got dout0=%h dout1=%h upd=%b ack=%b exp all 0", dout0, dout1, upd0, bus0.Sl_xferAck);
    end
    stray = 0;
    for (int c = 0; c < 2; c++) begin @(negedge clk); if (bus0.Sl_xferAck) stray++; end
    @(posedge clk); #1; sel0 = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin @(negedge clk); if (bus0.Sl_xferAck) stray++; end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL reset_stray_ack got %0d exp 0", stray); end
    exp_q.push_back(32'h0);
    xfer(0, 1'b1, BASE, 32'h0, 4'hF, 3, lat, nacks, dbad);
    checks++;
    if (lat !== 1 || nacks !== 1) begin
      errors++; $display("FAIL post_reset_ack got lat=%0d acks=%0d exp 1 1", lat, nacks);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL post_reset_read got %h exp %h", g, e); end
    end
  endtask

  initial begin
    clear_upd();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_direct_write();
    test_byte_enable();
    test_atomic();
    test_hold_select();
    test_back_to_back();
    test_reset_in_wait();
    checks++;
    if (exp_q.size() != 0 || got_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got exp=%0d got=%0d exp 0 0", exp_q.size(), got_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
